// File: rtl/mem_port_ctrl_if.sv
// mem_port_ctrl_if: groups every signal of one memory-port front-end
// except clock and reset.
//   Client request  : i_req_valid, o_req_ready, i_req_write, i_req_addr[12:0], i_req_wdata[63:0]
//   Client response : o_resp_valid, i_resp_ready, o_resp_data[63:0]
//   Memory port     : o_mem_op[1:0] (0 none, 1 read, 2 write), o_mem_addr[12:0],
//                     o_mem_data[63:0], i_mem_data[63:0]
//   Status          : o_busy, o_rd_count[31:0], o_wr_count[31:0]
// The slave modport is the controller; the master modport is the client/memory side.
interface mem_port_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [12:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [63:0] o_resp_data;
  logic [1:0]  o_mem_op;
  logic [12:0] o_mem_addr;
  logic [63:0] o_mem_data;
  logic [63:0] i_mem_data;
  logic        o_busy;
  logic [31:0] o_rd_count;
  logic [31:0] o_wr_count;

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_resp_ready, i_mem_data,
    output o_req_ready, o_resp_valid, o_resp_data, o_mem_op, o_mem_addr, o_mem_data,
           o_busy, o_rd_count, o_wr_count
  );

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_resp_ready, i_mem_data,
    input  o_req_ready, o_resp_valid, o_resp_data, o_mem_op, o_mem_addr, o_mem_data,
           o_busy, o_rd_count, o_wr_count
  );
endinterface

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: request front-end for one port of the 64-bit x 8192 memory.
// Buffers client requests in a REQ_DEPTH FIFO, issues at most one op per cycle
// onto the memory port (registered op/addr/data), and captures read data that
// returns one cycle after the op into a RESP_DEPTH response FIFO.
// Ports: i_clk, i_rst (async, active-high), bus (mem_port_ctrl_if.slave,
// carrying the request, response, memory-port and status signals).
// Optional build macro MEM_PORT_CTRL_STATS_EN: when defined, o_rd_count and
// o_wr_count count issued reads/writes; otherwise both are tied to 0.
module mem_port_ctrl #(
  parameter int REQ_DEPTH  = 4,
  parameter int RESP_DEPTH = 4
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_port_ctrl_if.slave bus
);
  localparam int REQ_AW  = $clog2(REQ_DEPTH);
  localparam int RESP_AW = $clog2(RESP_DEPTH);
  localparam int CRED_W  = RESP_AW + 2;
  localparam logic [1:0] OP_NONE  = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  logic            req_wr_mem   [REQ_DEPTH];
  logic [12:0]     req_addr_mem [REQ_DEPTH];
  logic [63:0]     req_data_mem [REQ_DEPTH];
  logic [REQ_AW:0] req_wptr_r, req_rptr_r;

  logic [63:0]      resp_mem [RESP_DEPTH];
  logic [RESP_AW:0] resp_wptr_r, resp_rptr_r;

  logic [1:0]  op_r;
  logic [12:0] addr_r;
  logic [63:0] data_r;
  logic        inflight_r;

  logic              req_empty_s, req_full_s, req_push_s, fifo_write_s, fifo_pop_s;
  logic              cand_valid_s, cand_write_s, read_ok_s, issue_s;
  logic [12:0]       cand_addr_s;
  logic [63:0]       cand_data_s;
  logic              resp_empty_s, resp_pop_s;
  logic [RESP_AW:0]  resp_count_s;
  logic [CRED_W-1:0] credit_used_s;

  assign req_empty_s = (req_wptr_r == req_rptr_r);
  assign req_full_s  = (req_wptr_r[REQ_AW] != req_rptr_r[REQ_AW]) &&
                       (req_wptr_r[REQ_AW-1:0] == req_rptr_r[REQ_AW-1:0]);
  assign req_push_s  = bus.i_req_valid && !req_full_s;

  assign resp_empty_s = (resp_wptr_r == resp_rptr_r);
  assign resp_count_s = resp_wptr_r - resp_rptr_r;
  assign resp_pop_s   = !resp_empty_s && bus.i_resp_ready;

  // Select the issue candidate: the FIFO head, or the incoming request when the FIFO is empty
  always_comb begin
    cand_valid_s = 1'b0;
    cand_write_s = 1'b0;
    cand_addr_s  = 13'd0;
    cand_data_s  = 64'd0;
    if (!req_empty_s) begin
      cand_valid_s = 1'b1;
      cand_write_s = req_wr_mem[req_rptr_r[REQ_AW-1:0]];
      cand_addr_s  = req_addr_mem[req_rptr_r[REQ_AW-1:0]];
      cand_data_s  = req_data_mem[req_rptr_r[REQ_AW-1:0]];
    end else begin
      cand_valid_s = req_push_s;
      cand_write_s = bus.i_req_write;
      cand_addr_s  = bus.i_req_addr;
      cand_data_s  = bus.i_req_wdata;
    end
  end

  // Read credit: every read on the port, in flight, or buffered holds one response slot;
  // a response leaving this cycle frees its slot immediately.
  always_comb begin
    credit_used_s = CRED_W'(resp_count_s) - CRED_W'(resp_pop_s)
                  + CRED_W'(op_r == OP_READ) + CRED_W'(inflight_r);
    read_ok_s     = (credit_used_s < CRED_W'(RESP_DEPTH));
    issue_s       = 1'b0;
    if (!cand_valid_s) begin
      issue_s = 1'b0;
    end else if (cand_write_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = read_ok_s;
    end
  end

  // A request that bypasses an empty FIFO is never stored
  assign fifo_write_s = req_push_s && !(req_empty_s && issue_s);
  assign fifo_pop_s   = issue_s && !req_empty_s;

  // Request FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge i_clk) begin
    if (fifo_write_s) begin
      req_wr_mem[req_wptr_r[REQ_AW-1:0]]   <= bus.i_req_write;
      req_addr_mem[req_wptr_r[REQ_AW-1:0]] <= bus.i_req_addr;
      req_data_mem[req_wptr_r[REQ_AW-1:0]] <= bus.i_req_wdata;
    end
  end

  // Response FIFO storage: capture returning read data the cycle after the read was on the port
  always_ff @(posedge i_clk) begin
    if (inflight_r) begin
      resp_mem[resp_wptr_r[RESP_AW-1:0]] <= bus.i_mem_data;
    end
  end

  // Pointers, registered memory-port outputs and the in-flight flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_wptr_r  <= '0;
      req_rptr_r  <= '0;
      resp_wptr_r <= '0;
      resp_rptr_r <= '0;
      op_r        <= OP_NONE;
      addr_r      <= 13'd0;
      data_r      <= 64'd0;
      inflight_r  <= 1'b0;
    end else begin
      if (fifo_write_s) req_wptr_r  <= req_wptr_r + 1'b1;
      if (fifo_pop_s)   req_rptr_r  <= req_rptr_r + 1'b1;
      if (inflight_r)   resp_wptr_r <= resp_wptr_r + 1'b1;
      if (resp_pop_s)   resp_rptr_r <= resp_rptr_r + 1'b1;
      // Flag marks the cycle in which the memory returns data for last cycle's read
      inflight_r <= (op_r == OP_READ);
      if (issue_s) begin
        op_r   <= cand_write_s ? OP_WRITE : OP_READ;
        addr_r <= cand_addr_s;
        data_r <= cand_write_s ? cand_data_s : 64'd0;
      end else begin
        op_r   <= OP_NONE;
        addr_r <= 13'd0;
        data_r <= 64'd0;
      end
    end
  end

`ifdef MEM_PORT_CTRL_STATS_EN
  logic [31:0] rd_count_r, wr_count_r;

  // Issue statistics, wrapping at 2^32
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_count_r <= 32'd0;
      wr_count_r <= 32'd0;
    end else if (issue_s) begin
      if (cand_write_s) wr_count_r <= wr_count_r + 32'd1;
      else              rd_count_r <= rd_count_r + 32'd1;
    end
  end

  assign bus.o_rd_count = rd_count_r;
  assign bus.o_wr_count = wr_count_r;
`else
  assign bus.o_rd_count = 32'd0;
  assign bus.o_wr_count = 32'd0;
`endif

  assign bus.o_req_ready  = !req_full_s;
  assign bus.o_resp_valid = !resp_empty_s;
  assign bus.o_resp_data  = resp_empty_s ? 64'd0 : resp_mem[resp_rptr_r[RESP_AW-1:0]];
  assign bus.o_mem_op     = op_r;
  assign bus.o_mem_addr   = addr_r;
  assign bus.o_mem_data   = data_r;
  assign bus.o_busy       = !req_empty_s || (op_r != OP_NONE) || inflight_r;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: self-checking bench for mem_port_ctrl (REQ_DEPTH=4, RESP_DEPTH=4).
// A behavioural memory sits on the memory port; a reference memory predicts read
// data at request-accept time and expected responses are queued in order.
module tb_mem_port_ctrl;
  logic clk;
  logic rst;
  mem_port_ctrl_if bus ();

  mem_port_ctrl #(.REQ_DEPTH(4), .RESP_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [63:0] mem     [8192];
  logic [63:0] ref_mem [8192];
  logic [63:0] mem_q;
  logic [63:0] exp_q [$];
  int n_cmp;
  int n_bad;
  int rd_issued;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    if (i == 0)                 return 64'd1;
    else if (i == 8)            return 64'd99;
    else if (i >= 16 && i < 32) return 64'hA000 + 64'(i);
    else                        return 64'd0;
  endfunction

  // Memory model: registers read data at the edge ending a read op, returns 0 otherwise
  always @(posedge clk) begin
    mem_q <= (bus.o_mem_op == 2'd1) ? mem[bus.o_mem_addr] : 64'd0;
    if (rst) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_word(i);
    end else if (bus.o_mem_op == 2'd2) begin
      mem[bus.o_mem_addr] <= bus.o_mem_data;
    end
  end
  assign bus.i_mem_data = mem_q;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: sample at the falling edge, return just after the rising edge
  task automatic cyc();
    @(negedge clk);
    if (!rst && bus.o_mem_op == 2'd1) rd_issued++;
    if (!rst && bus.o_resp_valid && bus.i_resp_ready) begin
      if (exp_q.size() == 0) check_val("resp_extra", 64'(exp_q.size()), 64'd1);
      else                   check_val("resp_data", bus.o_resp_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic wr, input logic [12:0] a, input logic [63:0] d);
    bit done;
    done = 1'b0;
    bus.i_req_valid = 1'b1;
    bus.i_req_write = wr;
    bus.i_req_addr  = a;
    bus.i_req_wdata = d;
    for (int k = 0; k < 200 && !done; k++) begin
      if (bus.o_req_ready) begin
        done = 1'b1;
        if (wr) ref_mem[a] = d;
        else    exp_q.push_back(ref_mem[a]);
      end
      cyc();
    end
    bus.i_req_valid = 1'b0;
    if (!done) check_val("req_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.o_busy) && k < budget) begin
      cyc();
      k++;
    end
    check_val("drain_done", 64'((exp_q.size() == 0) && !bus.o_busy), 64'd1);
  endtask

  initial begin
    int base;
    int k;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
    n_cmp = 0;
    n_bad = 0;
    rd_issued = 0;
    rst = 1'b1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_write  = 1'b0;
    bus.i_req_addr   = 13'd0;
    bus.i_req_wdata  = 64'd0;
    bus.i_resp_ready = 1'b0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    repeat (3) cyc();
    rst = 1'b0;
    repeat (10) cyc();

    // Idle after reset
    check_val("rst_mem_op",     64'(bus.o_mem_op),     64'd0);
    check_val("rst_mem_addr",   64'(bus.o_mem_addr),   64'd0);
    check_val("rst_req_ready",  64'(bus.o_req_ready),  64'd1);
    check_val("rst_resp_valid", 64'(bus.o_resp_valid), 64'd0);
    check_val("rst_resp_data",  bus.o_resp_data,       64'd0);
    check_val("rst_busy",       64'(bus.o_busy),       64'd0);
    check_val("rst_rd_count",   64'(bus.o_rd_count),   64'd0);
    check_val("rst_wr_count",   64'(bus.o_wr_count),   64'd0);

    // Single read: op one cycle after accept, response three cycles after
    bus.i_resp_ready = 1'b1;
    send(1'b0, 13'd8, 64'd0);
    check_val("rd8_op",   64'(bus.o_mem_op),   64'd1);
    check_val("rd8_addr", 64'(bus.o_mem_addr), 64'd8);
    cyc();
    check_val("rd8_early_valid", 64'(bus.o_resp_valid), 64'd0);
    cyc();
    check_val("rd8_valid", 64'(bus.o_resp_valid), 64'd1);
    check_val("rd8_data",  bus.o_resp_data,       64'd99);
    drain(20);

    // Write then read the same address back-to-back, plus a trailing read for order
    send(1'b1, 13'd5, 64'h1234);
    check_val("wr5_op",   64'(bus.o_mem_op),   64'd2);
    check_val("wr5_data", bus.o_mem_data,      64'h1234);
    send(1'b0, 13'd5, 64'd0);
    send(1'b0, 13'd0, 64'd0);
    drain(30);

    // Responses blocked: only RESP_DEPTH reads may be issued
    bus.i_resp_ready = 1'b0;
    base = rd_issued;
    for (int i = 0; i < 6; i++) send(1'b0, 13'(16 + i), 64'd0);
    repeat (6) cyc();
    check_val("blk_issued",     64'(rd_issued - base), 64'd4);
    check_val("blk_busy",       64'(bus.o_busy),       64'd1);
    check_val("blk_resp_valid", 64'(bus.o_resp_valid), 64'd1);
    bus.i_resp_ready = 1'b1;
    drain(60);
    check_val("blk_issued_all", 64'(rd_issued - base), 64'd6);

    // Request FIFO fills while reads are blocked, reopens once responses drain
    bus.i_resp_ready = 1'b0;
    base = rd_issued;
    for (int i = 0; i < 4; i++) send(1'b0, 13'(24 + i), 64'd0);
    repeat (4) cyc();
    for (int i = 0; i < 4; i++) send(1'b0, 13'(28 + i), 64'd0);
    check_val("fill_ready_low", 64'(bus.o_req_ready),  64'd0);
    check_val("fill_issued",    64'(rd_issued - base), 64'd4);
    bus.i_resp_ready = 1'b1;
    k = 0;
    while (!bus.o_req_ready && k < 20) begin
      cyc();
      k++;
    end
    check_val("fill_ready_reopen", 64'(bus.o_req_ready), 64'd1);
    drain(80);

    // Reset while a read's data is returning: nothing may come out afterwards
    send(1'b0, 13'd8, 64'd0);
    check_val("rstfl_op", 64'(bus.o_mem_op), 64'd1);
    cyc();
    rst = 1'b1;
    exp_q.delete();
    cyc();
    check_val("rstfl_op_none",    64'(bus.o_mem_op),     64'd0);
    check_val("rstfl_resp_empty", 64'(bus.o_resp_valid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_word(i);
    repeat (6) cyc();
    check_val("rstfl_no_stale", 64'(bus.o_resp_valid), 64'd0);
    check_val("rstfl_busy",     64'(bus.o_busy),       64'd0);

    // Statistics: 3 reads, 2 writes since reset
    send(1'b1, 13'd40, 64'd7);
    send(1'b0, 13'd40, 64'd0);
    send(1'b1, 13'd41, 64'd8);
    send(1'b0, 13'd41, 64'd0);
    send(1'b0, 13'd8,  64'd0);
    drain(40);
`ifdef MEM_PORT_CTRL_STATS_EN
    exp_rd = 32'd3;
    exp_wr = 32'd2;
`else
    exp_rd = 32'd0;
    exp_wr = 32'd0;
`endif
    check_val("stats_rd", 64'(bus.o_rd_count), 64'(exp_rd));
    check_val("stats_wr", 64'(bus.o_wr_count), 64'(exp_wr));

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
